fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_stage_if_id_reg.sv | 53 +++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// the instruction/PC constants used by the fetch stage and its IF/ID register.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold has priority, then flush, then load; otherwise a bubble.
// One-cycle latency; hold freezes the contents for the stalled decode stage.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        hold,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_dat,
    input  logic [31:0] pc_plus4_dat,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        vld_q, vld_d;

    always_comb begin
        instr_d = NOP_INSTR;
        pc4_d   = 32'h0;
        vld_d   = 1'b0;
        if (hold) begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            vld_d   = vld_q;
        end else if (!flush && load) begin
            instr_d = instr_dat;
            pc4_d   = pc_plus4_dat;
            vld_d   = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            vld_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            vld_q   <= vld_d;
        end
    end

    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pc4_q;
    assign IF_ID_Valid       = vld_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, IMEM request FSM, one-entry skid buffer, stall counter.
// IF/ID is one cycle behind a response; HazardStall freezes PC and IF/ID and parks a late response in the skid.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   HazardStall,
    input  logic                   BranchTaken,
    input  logic [31:0]            BranchTarget,
    output logic                   IMemReq,
    output logic [31:0]            IMemAddr,
    input  logic                   IMemValid,
    input  logic [31:0]            IMemData,
    output logic [31:0]            IF_ID_Instruction,
    output logic [31:0]            IF_ID_PCPlus4,
    output logic                   IF_ID_Valid,
    output logic [STALL_CNT_W-1:0] StallCount
);

    fetch_state_e           state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            target_q, target_d;
    logic [31:0]            skid_q, skid_d;
    logic                   skid_vld_q, skid_vld_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        branch_acc;
    logic [31:0] pc_plus4;
    logic        ifid_flush;
    logic        ifid_load;
    logic [31:0] ifid_instr;

    assign branch_acc = BranchTaken && !HazardStall;
    assign pc_plus4   = pc_q + PC_INCR;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        ifid_instr = IMemData;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (branch_acc) begin
                    pc_d       = BranchTarget;
                    ifid_flush = 1'b1;
                end
            end
            ST_REQ: begin
                if (HazardStall) begin
                    if (IMemValid) begin
                        skid_d     = IMemData;
                        skid_vld_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else if (branch_acc) begin
                    ifid_flush = 1'b1;
                    if (IMemValid) begin
                        pc_d = BranchTarget;
                    end else begin
                        target_d = BranchTarget;
                        state_d  = ST_DROP;
                    end
                end else if (IMemValid) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                end
            end
            ST_HOLD: begin
                if (!HazardStall) begin
                    skid_vld_d = 1'b0;
                    state_d    = ST_REQ;
                    if (branch_acc) begin
                        ifid_flush = 1'b1;
                        pc_d       = BranchTarget;
                    end else begin
                        ifid_load  = skid_vld_q;
                        ifid_instr = skid_q;
                        pc_d       = pc_plus4;
                    end
                end
            end
            ST_DROP: begin
                if (branch_acc) begin
                    target_d   = BranchTarget;
                    ifid_flush = 1'b1;
                end
                // The stale response carries no work, so retire it even under a stall.
                if (IMemValid) begin
                    state_d = ST_REQ;
                    pc_d    = branch_acc ? BranchTarget : target_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (HazardStall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            target_q    <= 32'h0;
            skid_q      <= NOP_INSTR;
            skid_vld_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            skid_q      <= skid_d;
            skid_vld_q  <= skid_vld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // DROP keeps the old address on the bus until the abandoned fetch completes.
    assign IMemReq    = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign IMemAddr   = pc_q;
    assign StallCount = stall_cnt_q;

    if_id_reg u_if_id_reg (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .hold              (HazardStall),
        .flush             (ifid_flush),
        .load              (ifid_load),
        .instr_dat         (ifid_instr),
        .pc_plus4_dat      (pc_plus4),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid)
    );

endmodule
